// File: rtl/ddr2_dma_pkg.sv
// Shared types and constants for the A-line DDR2 write DMA.
package ddr2_dma_pkg;

    localparam int DDR2_WORD_ADDR_W = 28;
    localparam int DATA_W           = 32;
    localparam logic [3:0] BYTEEN_ALL = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_SOP = 3'd1,
        ST_WRITE    = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_DONE     = 3'd4
    } dma_state_e;

    function automatic logic is_busy_state(input dma_state_e s);
        return (s == ST_WAIT_SOP) || (s == ST_WRITE) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/ddr2_dma_wr_fifo.sv
// Show-ahead FIFO: the head word is visible on rd_data the cycle after it is pushed.
module ddr2_dma_wr_fifo
    import ddr2_dma_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         pop,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign rd_data   = mem_r[rd_ptr_r];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Storage array; contents are meaningless once the pointers reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ddr2_aline_dma_writer.sv
// A-line framed streaming-to-Avalon-MM write DMA feeding the DDR2 clock-crossing bridge.
module ddr2_aline_dma_writer
    import ddr2_dma_pkg::*;
#(
    parameter int ALINE_LEN  = 1024,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        slave_clk,
    input  logic                        slave_reset_n,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        ring_mode,
    input  logic [DDR2_WORD_ADDR_W-1:0] base_addr,
    input  logic [15:0]                 num_alines,
    input  logic                        sink_valid,
    input  logic                        sink_sop,
    input  logic [DATA_W-1:0]           sink_data,
    output logic                        sink_ready,
    output logic [DDR2_WORD_ADDR_W-1:0] m_address,
    output logic [3:0]                  m_byteenable,
    output logic                        m_write,
    output logic                        m_read,
    output logic [DATA_W-1:0]           m_writedata,
    input  logic                        m_waitrequest,
    output logic                        busy,
    output logic                        done,
    output logic [15:0]                 aline_count,
    output logic                        sop_error,
    output logic                        overflow
);

    localparam int CNT_W  = $clog2(ALINE_LEN + 1);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(ALINE_LEN - 1);

    dma_state_e                  state_r;
    logic [DDR2_WORD_ADDR_W-1:0] base_r;
    logic [DDR2_WORD_ADDR_W-1:0] wr_addr_r;
    logic [15:0]                 num_r;
    logic                        ring_r;
    logic [CNT_W-1:0]            in_word_cnt_r;
    logic [CNT_W-1:0]            out_word_cnt_r;
    logic [15:0]                 in_lines_r;
    logic [15:0]                 out_lines_r;
    logic [15:0]                 aline_count_r;
    logic                        sop_error_r;
    logic                        overflow_r;
    logic                        stop_pending_r;
    logic                        done_r;

    logic                        start_go_s;
    logic                        sink_ready_s;
    logic                        accept_s;
    logic                        push_s;
    logic                        pop_s;
    logic                        end_capture_s;
    logic [15:0]                 in_lines_nxt_s;
    logic                        fifo_full_s;
    logic                        fifo_empty_s;
    logic [FCNT_W-1:0]           fifo_count_s;
    logic [DATA_W-1:0]           fifo_head_s;

    // Input-side handshake; a full FIFO also holds off the sop search so no word is lost.
    always_comb begin
        sink_ready_s = 1'b0;
        push_s       = 1'b0;
        case (state_r)
            ST_WAIT_SOP, ST_WRITE: sink_ready_s = ~fifo_full_s;
            default:               sink_ready_s = 1'b0;
        endcase
        accept_s = sink_valid & sink_ready_s;
        if (state_r == ST_WAIT_SOP) begin
            push_s = accept_s & sink_sop & ~stop;
        end else if (state_r == ST_WRITE) begin
            push_s = accept_s;
        end else begin
            push_s = 1'b0;
        end
    end

    assign start_go_s     = start & ((state_r == ST_IDLE) | (state_r == ST_DONE));
    assign pop_s          = ~fifo_empty_s & ~m_waitrequest;
    assign in_lines_nxt_s = in_lines_r + 16'd1;
    assign end_capture_s  = stop_pending_r | stop | (~ring_r & (in_lines_nxt_s == num_r));

    ddr2_dma_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (slave_clk),
        .rst_n   (slave_reset_n),
        .push    (push_s),
        .wr_data (sink_data),
        .pop     (pop_s),
        .rd_data (fifo_head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    // Capture FSM: A-line framing on the sink side, stop handling and sticky status.
    always_ff @(posedge slave_clk or negedge slave_reset_n) begin
        if (!slave_reset_n) begin
            state_r        <= ST_IDLE;
            base_r         <= {DDR2_WORD_ADDR_W{1'b0}};
            num_r          <= 16'd0;
            ring_r         <= 1'b0;
            in_word_cnt_r  <= {CNT_W{1'b0}};
            in_lines_r     <= 16'd0;
            sop_error_r    <= 1'b0;
            overflow_r     <= 1'b0;
            stop_pending_r <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        base_r         <= base_addr;
                        num_r          <= (num_alines == 16'd0) ? 16'd1 : num_alines;
                        ring_r         <= ring_mode;
                        in_word_cnt_r  <= {CNT_W{1'b0}};
                        in_lines_r     <= 16'd0;
                        sop_error_r    <= 1'b0;
                        overflow_r     <= 1'b0;
                        stop_pending_r <= 1'b0;
                        state_r        <= ST_WAIT_SOP;
                    end
                end
                ST_WAIT_SOP: begin
                    if (stop) begin
                        state_r <= ST_DRAIN;
                    end else if (push_s) begin
                        in_word_cnt_r <= CNT_W'(1);
                        state_r       <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (stop) stop_pending_r <= 1'b1;
                    if (sink_valid & ~sink_ready_s) overflow_r <= 1'b1;
                    if (accept_s) begin
                        if (sink_sop) begin
                            // Early sop: abandon the partial count, this word opens a new line.
                            sop_error_r   <= 1'b1;
                            in_word_cnt_r <= CNT_W'(1);
                        end else if (in_word_cnt_r == LINE_LAST) begin
                            in_word_cnt_r <= {CNT_W{1'b0}};
                            in_lines_r    <= in_lines_nxt_s;
                            state_r       <= end_capture_s ? ST_DRAIN : ST_WAIT_SOP;
                        end else begin
                            in_word_cnt_r <= in_word_cnt_r + CNT_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (fifo_count_s == {FCNT_W{1'b0}}) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Master side: address generation, ring wrap and completed-line counting.
    always_ff @(posedge slave_clk or negedge slave_reset_n) begin
        if (!slave_reset_n) begin
            wr_addr_r      <= {DDR2_WORD_ADDR_W{1'b0}};
            out_word_cnt_r <= {CNT_W{1'b0}};
            out_lines_r    <= 16'd0;
            aline_count_r  <= 16'd0;
        end else if (start_go_s) begin
            wr_addr_r      <= base_addr;
            out_word_cnt_r <= {CNT_W{1'b0}};
            out_lines_r    <= 16'd0;
            aline_count_r  <= 16'd0;
        end else if (pop_s) begin
            if (out_word_cnt_r == LINE_LAST) begin
                out_word_cnt_r <= {CNT_W{1'b0}};
                aline_count_r  <= aline_count_r + 16'd1;
                if (ring_r && ((out_lines_r + 16'd1) == num_r)) begin
                    wr_addr_r   <= base_r;
                    out_lines_r <= 16'd0;
                end else begin
                    wr_addr_r   <= wr_addr_r + DDR2_WORD_ADDR_W'(1);
                    out_lines_r <= out_lines_r + 16'd1;
                end
            end else begin
                out_word_cnt_r <= out_word_cnt_r + CNT_W'(1);
                wr_addr_r      <= wr_addr_r + DDR2_WORD_ADDR_W'(1);
            end
        end
    end

    assign sink_ready   = sink_ready_s;
    assign m_address    = wr_addr_r;
    assign m_writedata  = fifo_head_s;
    assign m_write      = ~fifo_empty_s;
    assign m_byteenable = m_write ? BYTEEN_ALL : 4'h0;
    assign m_read       = 1'b0;
    assign busy         = is_busy_state(state_r);
    assign done         = done_r;
    assign aline_count  = aline_count_r;
    assign sop_error    = sop_error_r;
    assign overflow     = overflow_r;

endmodule

// File: tb/tb_ddr2_aline_dma_writer.sv
// Directed bench for ddr2_aline_dma_writer with ALINE_LEN=8 and a write scoreboard.
module tb_ddr2_aline_dma_writer;

    logic        slave_clk;
    logic        slave_reset_n;
    logic        start;
    logic        stop;
    logic        ring_mode;
    logic [27:0] base_addr;
    logic [15:0] num_alines;
    logic        sink_valid;
    logic        sink_sop;
    logic [31:0] sink_data;
    logic        sink_ready;
    logic [27:0] m_address;
    logic [3:0]  m_byteenable;
    logic        m_write;
    logic        m_read;
    logic [31:0] m_writedata;
    logic        m_waitrequest;
    logic        busy;
    logic        done;
    logic [15:0] aline_count;
    logic        sop_error;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;
    int wr_mode  = 0;
    int cyc      = 0;
    int stab_err = 0;
    int be_err   = 0;

    logic [27:0] cap_addr[$];
    logic [31:0] cap_data[$];
    logic [27:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic        prev_hold;
    logic [27:0] prev_addr;
    logic [31:0] prev_data;

    ddr2_aline_dma_writer #(.ALINE_LEN(8), .FIFO_DEPTH(16)) dut (
        .slave_clk     (slave_clk),
        .slave_reset_n (slave_reset_n),
        .start         (start),
        .stop          (stop),
        .ring_mode     (ring_mode),
        .base_addr     (base_addr),
        .num_alines    (num_alines),
        .sink_valid    (sink_valid),
        .sink_sop      (sink_sop),
        .sink_data     (sink_data),
        .sink_ready    (sink_ready),
        .m_address     (m_address),
        .m_byteenable  (m_byteenable),
        .m_write       (m_write),
        .m_read        (m_read),
        .m_writedata   (m_writedata),
        .m_waitrequest (m_waitrequest),
        .busy          (busy),
        .done          (done),
        .aline_count   (aline_count),
        .sop_error     (sop_error),
        .overflow      (overflow)
    );

    initial begin
        slave_clk = 1'b0;
        forever #5 slave_clk = ~slave_clk;
    end

    // Bridge backpressure: mode 1 stalls 3 of every 4 cycles, mode 2 stalls continuously.
    initial begin
        m_waitrequest = 1'b0;
        forever begin
            @(posedge slave_clk);
            #1;
            cyc = cyc + 1;
            m_waitrequest = (wr_mode == 2) || ((wr_mode == 1) && ((cyc % 4) != 3));
        end
    end

    // Capture completed writes and watch for master outputs changing under waitrequest.
    always @(posedge slave_clk) begin
        if (!slave_reset_n) begin
            prev_hold <= 1'b0;
        end else begin
            if (prev_hold && (m_write !== 1'b1 || m_address !== prev_addr || m_writedata !== prev_data))
                stab_err <= stab_err + 1;
            if ((m_write && m_byteenable !== 4'hF) || (!m_write && m_byteenable !== 4'h0) || m_read !== 1'b0)
                be_err <= be_err + 1;
            if (m_write && !m_waitrequest) begin
                cap_addr.push_back(m_address);
                cap_data.push_back(m_writedata);
            end
            prev_hold <= m_write && m_waitrequest;
            prev_addr <= m_address;
            prev_data <= m_writedata;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [27:0] base, input logic [15:0] num, input logic ring);
        @(negedge slave_clk);
        sink_valid = 1'b0;
        base_addr  = base;
        num_alines = num;
        ring_mode  = ring;
        start      = 1'b1;
        @(negedge slave_clk);
        start      = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic s);
        int n = 0;
        @(negedge slave_clk);
        while (!sink_ready && n < 200) begin
            sink_valid = 1'b0;
            @(negedge slave_clk);
            n = n + 1;
        end
        if (n >= 200) begin
            n_checks = n_checks + 1;
            n_errors = n_errors + 1;
            $display("FAIL send_timeout: sink_ready stayed 0 for word 0x%0h", d);
        end else begin
            sink_valid = 1'b1;
            sink_sop   = s;
            sink_data  = d;
        end
    endtask

    task automatic send_range(input logic [31:0] d0, input int lo, input int hi);
        for (int i = lo; i < hi; i++) send_word(d0 + 32'(i), (i == 0));
    endtask

    task automatic expect_range(input logic [27:0] a0, input logic [31:0] d0, input int n);
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(a0 + 28'(i));
            exp_data.push_back(d0 + 32'(i));
        end
    endtask

    task automatic pulse_stop();
        @(negedge slave_clk);
        sink_valid = 1'b0;
        stop       = 1'b1;
        @(negedge slave_clk);
        stop       = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int hi = 0;
        @(negedge slave_clk);
        sink_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done) hi = hi + 1;
            if (hi > 0 && !done) break;
            @(negedge slave_clk);
        end
        check_eq({tag, "_done_cycles"}, 64'(hi), 64'd1);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic compare_writes(input string tag);
        check_eq({tag, "_nwrites"}, 64'(cap_addr.size()), 64'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < cap_addr.size(); i++) begin
            check_eq($sformatf("%s_addr%0d", tag, i), 64'(cap_addr[i]), 64'(exp_addr[i]));
            check_eq($sformatf("%s_data%0d", tag, i), 64'(cap_data[i]), 64'(exp_data[i]));
        end
        cap_addr.delete();
        cap_data.delete();
        exp_addr.delete();
        exp_data.delete();
    endtask

    initial begin
        slave_reset_n = 1'b0;
        start = 1'b0; stop = 1'b0; ring_mode = 1'b0;
        base_addr = 28'd0; num_alines = 16'd0;
        sink_valid = 1'b0; sink_sop = 1'b0; sink_data = 32'd0;
        #1;
        check_eq("rst_sink_ready", 64'(sink_ready), 64'd0);
        check_eq("rst_m_write", 64'(m_write), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_aline_count", 64'(aline_count), 64'd0);
        check_eq("rst_flags", 64'({sop_error, overflow}), 64'd0);
        repeat (3) @(negedge slave_clk);
        slave_reset_n = 1'b1;

        // One-shot, two lines, no backpressure.
        do_start(28'h100, 16'd2, 1'b0);
        check_eq("t1_busy", 64'(busy), 64'd1);
        send_range(32'hA000_0000, 0, 8);
        send_range(32'hB000_0000, 0, 8);
        expect_range(28'h100, 32'hA000_0000, 8);
        expect_range(28'h108, 32'hB000_0000, 8);
        wait_done("t1");
        check_eq("t1_aline_count", 64'(aline_count), 64'd2);
        check_eq("t1_flags", 64'({sop_error, overflow}), 64'd0);
        compare_writes("t1");

        // Same transfer under 3-in-4 waitrequest.
        wr_mode = 1;
        do_start(28'h100, 16'd2, 1'b0);
        send_range(32'hC000_0000, 0, 8);
        send_range(32'hD000_0000, 0, 8);
        expect_range(28'h100, 32'hC000_0000, 8);
        expect_range(28'h108, 32'hD000_0000, 8);
        wait_done("t2");
        check_eq("t2_aline_count", 64'(aline_count), 64'd2);
        compare_writes("t2");
        wr_mode = 0;

        // Ring of two lines, five streamed, stop issued once line 5 has started.
        do_start(28'h100, 16'd2, 1'b1);
        for (int l = 1; l <= 4; l++) begin
            send_range(32'h3000_0000 + 32'(l) * 32'h100, 0, 8);
            expect_range(28'h100 + 28'((l - 1) % 2) * 28'd8, 32'h3000_0000 + 32'(l) * 32'h100, 8);
        end
        send_range(32'h3000_0500, 0, 1);
        pulse_stop();
        send_range(32'h3000_0500, 1, 8);
        expect_range(28'h100, 32'h3000_0500, 8);
        wait_done("t3");
        check_eq("t3_aline_count", 64'(aline_count), 64'd5);
        check_eq("t3_sop_error", 64'(sop_error), 64'd0);
        compare_writes("t3");

        // Leading non-sop words are dropped.
        do_start(28'h200, 16'd1, 1'b0);
        for (int i = 0; i < 3; i++) send_word(32'hDEAD_0000 + 32'(i), 1'b0);
        send_range(32'h4000_0000, 0, 8);
        expect_range(28'h200, 32'h4000_0000, 8);
        wait_done("t4");
        check_eq("t4_aline_count", 64'(aline_count), 64'd1);
        compare_writes("t4");

        // Early sop with the bridge stalled: realignment, FIFO full, overflow.
        wr_mode = 2;
        do_start(28'h300, 16'd2, 1'b0);
        send_range(32'hE000_0000, 0, 5);
        send_range(32'hF000_0000, 0, 8);
        send_range(32'h6000_0000, 0, 3);
        @(negedge slave_clk);
        sink_valid = 1'b0;
        check_eq("t5_full_ready", 64'(sink_ready), 64'd0);
        check_eq("t5_sop_error", 64'(sop_error), 64'd1);
        check_eq("t5_no_overflow", 64'(overflow), 64'd0);
        sink_valid = 1'b1; sink_sop = 1'b0; sink_data = 32'h0BAD_0BAD;
        @(negedge slave_clk);
        sink_valid = 1'b0;
        check_eq("t5_overflow", 64'(overflow), 64'd1);
        wr_mode = 0;
        send_range(32'h6000_0000, 3, 8);
        expect_range(28'h300, 32'hE000_0000, 5);
        expect_range(28'h305, 32'hF000_0000, 8);
        expect_range(28'h30D, 32'h6000_0000, 8);
        wait_done("t5");
        check_eq("t5_aline_count", 64'(aline_count), 64'd2);
        compare_writes("t5");

        // Asynchronous reset while a write is held by waitrequest.
        wr_mode = 2;
        do_start(28'h400, 16'd1, 1'b0);
        send_range(32'h7000_0000, 0, 3);
        @(negedge slave_clk);
        sink_valid = 1'b0;
        check_eq("t6_pre_mwrite", 64'(m_write), 64'd1);
        #2 slave_reset_n = 1'b0;
        #1;
        check_eq("t6_rst_mwrite", 64'(m_write), 64'd0);
        check_eq("t6_rst_busy", 64'(busy), 64'd0);
        check_eq("t6_rst_ready", 64'(sink_ready), 64'd0);
        @(negedge slave_clk);
        slave_reset_n = 1'b1;
        wr_mode = 0;
        cap_addr.delete();
        cap_data.delete();
        do_start(28'h500, 16'd1, 1'b0);
        check_eq("t6_overflow_clr", 64'(overflow), 64'd0);
        send_range(32'h8000_0000, 0, 8);
        expect_range(28'h500, 32'h8000_0000, 8);
        wait_done("t6");
        check_eq("t6_aline_count", 64'(aline_count), 64'd1);
        compare_writes("t6");

        check_eq("stable_under_wait", 64'(stab_err), 64'd0);
        check_eq("byteenable_read", 64'(be_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
